reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Architectural register file with rename status: 32 x 32-bit values, plus a per-register busy bit and the RoB tag of the youngest in-flight producer.
- Sits between RoB and decoder:
  - RoB issue port marks destination registers renamed.
  - RoB commit port writes retired values.
  - Decoder reads operand value or tag combinationally.
  - Flush (`clear`) drops all renames; architectural values are kept.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hardwired zero).
- TAG_W, `ROB_SIZE_WIDTH`, RoB tag width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rdy  in  1  global ready; when 0, no state changes.
- clear  in  1  RoB flush; drops all busy bits.
- issue_valid  in  1  an instruction is issued this cycle.
- issue_rd  in  5  destination register of issued instruction.
- issue_rob_id  in  TAG_W  RoB tag of issued instruction.
- commit_valid  in  1  RoB retires a register-writing instruction.
- commit_rd  in  5  retired destination.
- commit_rob_id  in  TAG_W  retired tag.
- commit_value  in  32  retired result.
- rs1  in  5  decoder source 1 index.
- rs2  in  5  decoder source 2 index.
- val1  out  32  source 1 value.
- val2  out  32  source 2 value.
- busy1  out  1  source 1 pending in RoB.
- busy2  out  1  source 2 pending in RoB.
- tag1  out  TAG_W  producer tag for source 1.
- tag2  out  TAG_W  producer tag for source 2.

Behaviour:
- Reset (rst=0, async):
  - All values cleared to 0, busy cleared to 0, tags cleared to 0.
  - Outputs therefore read 0 / not busy.
- Updates happen on the clk rising edge, only when rdy=1. When rdy=0, all state holds.
- Commit, when commit_valid && commit_rd!=0:
  - values[commit_rd] <= commit_value.
  - busy[commit_rd] <= 0 only if tags[commit_rd]==commit_rob_id; otherwise busy is kept, because a younger producer owns the register.
- Issue, when issue_valid && issue_rd!=0 && !clear:
  - busy[issue_rd] <= 1 and tags[issue_rd] <= issue_rob_id.
  - Issue takes priority over the commit busy-clear on the same register in the same cycle; the commit value is still written.
- Clear (clear && rdy):
  - All busy bits <= 0 and all tags <= 0.
  - Same-cycle commit is still performed: its value is written.
  - Same-cycle issue is ignored.
- x0:
  - Writes and issues to rd=0 are ignored.
  - Reads of x0 always return val=0, busy=0, tag=0.
- Read ports are combinational, with zero latency:
  - val = values[rs], busy = busy[rs], tag = tags[rs].
  - Same-cycle issue is NOT forwarded to reads; the decoder handles intra-cycle dependency.
- Tag wrap-around: tags are compared by equality only, so RoB wrap needs no special handling.

Optional Feature:
- Macro: REG_COMMIT_BYPASS_EN.
- Defined: same-cycle commit is forwarded to the read ports. If commit_valid && rdy && commit_rd==rs && commit_rd!=0:
  - val = commit_value.
  - busy = 0 if tags[rs]==commit_rob_id, else busy/tag unchanged.
- Undefined: reads return registered state only. The decoder then obtains the value through the RoB get_value path one cycle earlier.

Decomposition:
- Shared config.v:
  - `ROB_SIZE_WIDTH`.
  - `REG_NUM` (32).
  - `REG_IDX_WIDTH` (5).
- Sub-module reg_entry: one register's value/busy/tag with issue/commit/clear priority logic. Instantiated 31 times via generate; x0 is a constant.
- Read muxes and optional bypass live in the top module.

Test Plan:
- Reset check: hold rst=0 with random inputs, then release → every rs reads val=0, busy=0, tag=0.
- Issue then commit: issue rd=5, tag=3 → busy1=1, tag1=3 for rs1=5; next cycle commit rd=5, tag=3, value=0xDEADBEEF → val1=0xDEADBEEF, busy1=0.
- Stale commit: issue rd=7 tag=2, then issue rd=7 tag=4, then commit rd=7 tag=2 value=0x11 → val=0x11, busy=1, tag=4.
- Simultaneous issue and commit: same cycle issue rd=9 tag=6 and commit rd=9 tag=1 value=0x22 → val=0x22, busy=1, tag=6.
- Flush: busy on x3, x4 (tags 1, 2); assert clear together with issue rd=8 → next cycle all busy=0 and x8 not busy. Also commit rd=3 value=0x33 in the clear cycle → val=0x33.
- x0 and rdy: issue/commit rd=0 value=0x55 → x0 reads 0/0/0. With rdy=0, commit rd=10 value=0x77 → val unchanged. With REG_COMMIT_BYPASS_EN defined, commit rd=10 value=0x77 matching tag → val1=0x77 in the same cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared constants for the architectural register file and its per-register
//   entries: RoB tag width, register count and register index width.
//   Also provides the commit-to-read forwarding match used by the optional
//   bypass (REG_COMMIT_BYPASS_EN).
package reg_file_pkg;

    localparam int ROB_SIZE_WIDTH = 4;
    localparam int RF_REG_NUM     = 32;
    localparam int RF_IDX_W       = 5;

    typedef logic [RF_IDX_W-1:0] reg_idx_t;

    // True when a commit this cycle targets the register being read.
    // x0 never matches because it is hardwired.
    function automatic logic commit_hits(input logic     valid,
                                         input logic     rdy,
                                         input reg_idx_t rd,
                                         input reg_idx_t rs);
        return valid && rdy && (rd == rs) && (rd != '0);
    endfunction

endpackage

// File: rtl/reg_file_entry.sv
// reg_entry
//   One architectural register: value, busy bit and youngest-producer RoB tag.
//   Applies commit, issue and clear with the required priorities.
//
// Ports
//   clk, rst           clock (rising edge), async active-low reset
//   rdy                state only moves when high
//   clear              flush: drop busy/tag, keep value
//   issue_*            rename request (valid, rd, rob tag)
//   commit_*           retire request (valid, rd, rob tag, value)
//   value, busy, tag   current register state
module reg_entry
    import reg_file_pkg::*;
#(
    parameter int IDX   = 1,
    parameter int TAG_W = ROB_SIZE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic [TAG_W-1:0] issue_rob_id,
    input  logic             commit_valid,
    input  logic [4:0]       commit_rd,
    input  logic [TAG_W-1:0] commit_rob_id,
    input  logic [31:0]      commit_value,
    output logic [31:0]      value,
    output logic             busy,
    output logic [TAG_W-1:0] tag
);

    localparam logic [4:0] MY_IDX = 5'(IDX);

    logic issue_hit;
    logic commit_hit;

    assign issue_hit  = issue_valid  && (issue_rd  == MY_IDX);
    assign commit_hit = commit_valid && (commit_rd == MY_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
            busy  <= 1'b0;
            tag   <= '0;
        end else if (rdy) begin
            // The retired value is architectural and is written regardless
            // of rename state or flush.
            if (commit_hit)
                value <= commit_value;

            if (clear) begin
                busy <= 1'b0;
                tag  <= '0;
            end else if (issue_hit) begin
                // A new rename wins over any same-cycle busy release.
                busy <= 1'b1;
                tag  <= issue_rob_id;
            end else if (commit_hit && (tag == commit_rob_id)) begin
                // Only the youngest producer may release the register.
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// reg_file
//   32 x 32-bit architectural register file with rename status (busy bit and
//   youngest in-flight RoB tag per register). x0 is hardwired to zero.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   rdy                      global ready; no state change when low
//   clear                    RoB flush; drops all renames
//   issue_valid/rd/rob_id    mark destination renamed
//   commit_valid/rd/rob_id/value   write retired value
//   rs1, rs2                 decoder read indices
//   val1/2, busy1/2, tag1/2  combinational read data
//
// Build option
//   REG_COMMIT_BYPASS_EN     forward a same-cycle commit to the read ports
module reg_file
    import reg_file_pkg::*;
#(
    parameter int REG_NUM = RF_REG_NUM,
    parameter int TAG_W   = ROB_SIZE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic [TAG_W-1:0] issue_rob_id,
    input  logic             commit_valid,
    input  logic [4:0]       commit_rd,
    input  logic [TAG_W-1:0] commit_rob_id,
    input  logic [31:0]      commit_value,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic [31:0]      val1,
    output logic [31:0]      val2,
    output logic             busy1,
    output logic             busy2,
    output logic [TAG_W-1:0] tag1,
    output logic [TAG_W-1:0] tag2
);

    logic [31:0]      values [REG_NUM];
    logic             busys  [REG_NUM];
    logic [TAG_W-1:0] tags   [REG_NUM];

    assign values[0] = '0;
    assign busys[0]  = 1'b0;
    assign tags[0]   = '0;

    for (genvar i = 1; i < REG_NUM; i++) begin : g_entry
        reg_entry #(
            .IDX   (i),
            .TAG_W (TAG_W)
        ) u_entry (
            .clk           (clk),
            .rst           (rst),
            .rdy           (rdy),
            .clear         (clear),
            .issue_valid   (issue_valid),
            .issue_rd      (issue_rd),
            .issue_rob_id  (issue_rob_id),
            .commit_valid  (commit_valid),
            .commit_rd     (commit_rd),
            .commit_rob_id (commit_rob_id),
            .commit_value  (commit_value),
            .value         (values[i]),
            .busy          (busys[i]),
            .tag           (tags[i])
        );
    end

    // Same-cycle issue is deliberately not forwarded; the decoder resolves
    // intra-cycle dependencies itself.
    always_comb begin
        val1  = values[rs1];
        busy1 = busys[rs1];
        tag1  = tags[rs1];
`ifdef REG_COMMIT_BYPASS_EN
        if (commit_hits(commit_valid, rdy, commit_rd, rs1)) begin
            val1 = commit_value;
            if (tags[rs1] == commit_rob_id)
                busy1 = 1'b0;
        end
`endif
    end

    always_comb begin
        val2  = values[rs2];
        busy2 = busys[rs2];
        tag2  = tags[rs2];
`ifdef REG_COMMIT_BYPASS_EN
        if (commit_hits(commit_valid, rdy, commit_rd, rs2)) begin
            val2 = commit_value;
            if (tags[rs2] == commit_rob_id)
                busy2 = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;
    import reg_file_pkg::*;

    localparam int TW = ROB_SIZE_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic          clear;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic [TW-1:0] issue_rob_id;
    logic          commit_valid;
    logic [4:0]    commit_rd;
    logic [TW-1:0] commit_rob_id;
    logic [31:0]   commit_value;
    logic [4:0]    rs1, rs2;
    logic [31:0]   val1, val2;
    logic          busy1, busy2;
    logic [TW-1:0] tag1, tag2;

    int checks   = 0;
    int failures = 0;

    reg_file dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .clear         (clear),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_rob_id  (issue_rob_id),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
        .rs1           (rs1),
        .rs2           (rs2),
        .val1          (val1),
        .val2          (val2),
        .busy1         (busy1),
        .busy2         (busy2),
        .tag1          (tag1),
        .tag2          (tag2)
    );

    always #5 clk = ~clk;

    // Reference model: architectural state as plain arrays.
    logic [31:0]   m_val  [32];
    logic          m_busy [32];
    logic [TW-1:0] m_tag  [32];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
        end
    endtask

    // Applies one clock of the rules to the model, from the currently driven inputs.
    task automatic model_tick();
        logic match;
        if (!rdy) return;
        match = (m_tag[commit_rd] == commit_rob_id);
        if (commit_valid && commit_rd != 0) m_val[commit_rd] = commit_value;
        if (clear) begin
            for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
        end else begin
            if (commit_valid && commit_rd != 0 && match) m_busy[commit_rd] = 0;
            if (issue_valid && issue_rd != 0) begin
                m_busy[issue_rd] = 1; m_tag[issue_rd] = issue_rob_id;
            end
        end
    endtask

    task automatic model_read(input logic [4:0] rs, output logic [31:0] v,
                              output logic b, output logic [TW-1:0] t);
        v = m_val[rs]; b = m_busy[rs]; t = m_tag[rs];
`ifdef REG_COMMIT_BYPASS_EN
        if (commit_valid && rdy && commit_rd == rs && rs != 0) begin
            v = commit_value;
            if (m_tag[rs] == commit_rob_id) b = 0;
        end
`endif
        if (rs == 0) begin v = 0; b = 0; t = 0; end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tagname);
        logic [31:0] v; logic b; logic [TW-1:0] t;
        model_read(rs1, v, b, t);
        chk({tagname, " val1"}, val1, v);
        chk({tagname, " busy1"}, 32'(busy1), 32'(b));
        chk({tagname, " tag1"}, 32'(tag1), 32'(t));
        model_read(rs2, v, b, t);
        chk({tagname, " val2"}, val2, v);
        chk({tagname, " busy2"}, 32'(busy2), 32'(b));
        chk({tagname, " tag2"}, 32'(tag2), 32'(t));
    endtask

    task automatic drive(input logic r, input logic c, input logic iv, input logic [4:0] ird,
                         input logic [TW-1:0] itag, input logic cv, input logic [4:0] crd,
                         input logic [TW-1:0] ctag, input logic [31:0] cval,
                         input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        rdy = r; clear = c; issue_valid = iv; issue_rd = ird; issue_rob_id = itag;
        commit_valid = cv; commit_rd = crd; commit_rob_id = ctag; commit_value = cval;
        rs1 = a; rs2 = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
    endtask

    typedef struct {
        logic          r, c, iv;
        logic [4:0]    ird;
        logic [TW-1:0] itag;
        logic          cv;
        logic [4:0]    crd;
        logic [TW-1:0] ctag;
        logic [31:0]   cval;
        logic [4:0]    rs;
        logic [31:0]   ev;
        logic          eb;
        logic [TW-1:0] et;
    } vec_t;

    vec_t vecs [20];

    initial begin
        // Expected columns describe rs1 as read during the row's cycle (state before its edge).
        //          r  c  iv ird itag cv crd ctag cval          rs  ev            eb  et
        vecs[0]  = '{1, 0, 1, 5,  3,   0, 0,  0,   32'h0,        5,  32'h0,        0, 0};
        vecs[1]  = '{1, 0, 0, 0,  0,   0, 0,  0,   32'h0,        5,  32'h0,        1, 3};
        vecs[2]  = '{1, 0, 0, 0,  0,   1, 5,  3,   32'hDEADBEEF, 1,  32'h0,        0, 0};
        vecs[3]  = '{1, 0, 0, 0,  0,   0, 0,  0,   32'h0,        5,  32'hDEADBEEF, 0, 3};
        vecs[4]  = '{1, 0, 1, 7,  2,   0, 0,  0,   32'h0,        7,  32'h0,        0, 0};
        vecs[5]  = '{1, 0, 1, 7,  4,   0, 0,  0,   32'h0,        7,  32'h0,        1, 2};
        vecs[6]  = '{1, 0, 0, 0,  0,   1, 7,  2,   32'h11,       5,  32'hDEADBEEF, 0, 3};
        vecs[7]  = '{1, 0, 1, 9,  6,   1, 9,  1,   32'h22,       7,  32'h11,       1, 4};
        vecs[8]  = '{1, 0, 1, 3,  1,   0, 0,  0,   32'h0,        9,  32'h22,       1, 6};
        vecs[9]  = '{1, 0, 1, 4,  2,   0, 0,  0,   32'h0,        3,  32'h0,        1, 1};
        vecs[10] = '{1, 1, 1, 8,  5,   1, 3,  7,   32'h33,       4,  32'h0,        1, 2};
        vecs[11] = '{1, 0, 0, 0,  0,   0, 0,  0,   32'h0,        3,  32'h33,       0, 0};
        vecs[12] = '{1, 0, 0, 0,  0,   0, 0,  0,   32'h0,        8,  32'h0,        0, 0};
        vecs[13] = '{1, 0, 0, 0,  0,   0, 0,  0,   32'h0,        9,  32'h22,       0, 0};
        vecs[14] = '{1, 0, 0, 0,  0,   0, 0,  0,   32'h0,        4,  32'h0,        0, 0};
        vecs[15] = '{1, 0, 1, 0,  3,   1, 0,  0,   32'h55,       7,  32'h11,       0, 0};
        vecs[16] = '{1, 0, 0, 0,  0,   0, 0,  0,   32'h0,        0,  32'h0,        0, 0};
        vecs[17] = '{0, 0, 1, 11, 9,   1, 10, 0,   32'h77,       0,  32'h0,        0, 0};
        vecs[18] = '{1, 0, 0, 0,  0,   0, 0,  0,   32'h0,        10, 32'h0,        0, 0};
        vecs[19] = '{1, 0, 0, 0,  0,   0, 0,  0,   32'h0,        11, 32'h0,        0, 0};

        // Reset held while inputs toggle randomly.
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rdy = 1'b1; clear = 1'($urandom); issue_valid = 1'($urandom);
            issue_rd = 5'($urandom); issue_rob_id = TW'($urandom);
            commit_valid = 1'($urandom); commit_rd = 5'($urandom);
            commit_rob_id = TW'($urandom); commit_value = $urandom;
            rs1 = 5'($urandom); rs2 = 5'($urandom);
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i);
            #1;
            chk("reset val1", val1, 0);
            chk("reset busy1", 32'(busy1), 0);
            chk("reset tag1", 32'(tag1), 0);
            chk("reset val2", val2, 0);
        end

        // Directed table.
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].r, vecs[i].c, vecs[i].iv, vecs[i].ird, vecs[i].itag,
                  vecs[i].cv, vecs[i].crd, vecs[i].ctag, vecs[i].cval, vecs[i].rs, 5'd10);
            chk($sformatf("vec%0d val", i), val1, vecs[i].ev);
            chk($sformatf("vec%0d busy", i), 32'(busy1), 32'(vecs[i].eb));
            chk($sformatf("vec%0d tag", i), 32'(tag1), 32'(vecs[i].et));
            check_model($sformatf("vec%0d model", i));
            tick();
        end

        // Commit matching the current tag of x10, read in the same cycle.
        drive(1, 0, 1, 10, 5, 0, 0, 0, 0, 10, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 10, 5, 32'h77, 10, 10);
`ifdef REG_COMMIT_BYPASS_EN
        chk("bypass val1", val1, 32'h77);
        chk("bypass busy1", 32'(busy1), 0);
`else
        chk("nobypass val1", val1, 32'h0);
        chk("nobypass busy1", 32'(busy1), 1);
`endif
        check_model("bypass model");
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 10, 0);
        chk("after commit val1", val1, 32'h77);
        chk("after commit busy1", 32'(busy1), 0);
        tick();

        // Random traffic on a small register window to force collisions.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] ird, crd;
            logic [TW-1:0] ctag;
            ird = 5'($urandom_range(0, 7));
            crd = 5'($urandom_range(0, 7));
            ctag = ($urandom_range(0, 1) == 0) ? m_tag[crd] : TW'($urandom);
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
                  1'($urandom), ird, TW'($urandom), 1'($urandom), crd, ctag, $urandom,
                  5'($urandom_range(0, 8)), 5'($urandom_range(0, 8)));
            check_model("rand");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
